// File: rtl/new_usb_nonperiodic_arbiter.sv
// new_usb_nonperiodic_arbiter
//   Arbitrates between the OHCI control and bulk endpoint-descriptor lists.
//   While nonperiodic processing is allowed, the control list is served
//   ratio_i+1 EDs for every bulk ED. A list is eligible only when it is both
//   enabled and filled. The grant comes from a registered state, so it changes
//   one cycle after the input that causes the change.
//
// Ports
//   clk_i              : clock
//   rst_ni             : asynchronous active-low reset
//   nonperiodic_en_i   : nonperiodic processing allowed this frame
//   control_enable_i   : control list enable (CLE)
//   bulk_enable_i      : bulk list enable (BLE)
//   control_filled_i   : control list filled (CLF)
//   bulk_filled_i      : bulk list filled (BLF)
//   ratio_i            : control:bulk ratio (ratio_i+1 control EDs per bulk ED)
//   served_control_i   : level "control ED served"; only rising edges count
//   served_bulk_i      : level "bulk ED served"; only rising edges count
//   select_control_o   : control list granted
//   select_bulk_o      : bulk list granted
//   idle_o             : no list granted
//   count_o            : control EDs remaining before the bulk turn
//   last_control_o     : the next served control ED completes the ratio
module new_usb_nonperiodic_arbiter #(
  parameter int unsigned RATIO_WIDTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   nonperiodic_en_i,
  input  logic                   control_enable_i,
  input  logic                   bulk_enable_i,
  input  logic                   control_filled_i,
  input  logic                   bulk_filled_i,
  input  logic [RATIO_WIDTH-1:0] ratio_i,
  input  logic                   served_control_i,
  input  logic                   served_bulk_i,
  output logic                   select_control_o,
  output logic                   select_bulk_o,
  output logic                   idle_o,
  output logic [RATIO_WIDTH-1:0] count_o,
  output logic                   last_control_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONTROL = 2'd1,
    ST_BULK    = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [RATIO_WIDTH-1:0] count_reg, count_next;
  logic                   served_control_reg;
  logic                   served_bulk_reg;

  logic control_eligible;
  logic bulk_eligible;
  logic control_event;
  logic bulk_event;

  assign control_eligible = control_enable_i & control_filled_i;
  assign bulk_eligible    = bulk_enable_i & bulk_filled_i;

  // A served indication counts once per rising edge, however long it is held.
  assign control_event = served_control_i & ~served_control_reg;
  assign bulk_event    = served_bulk_i & ~served_bulk_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg          <= ST_IDLE;
      count_reg          <= '0;
      served_control_reg <= 1'b0;
      served_bulk_reg    <= 1'b0;
    end else begin
      state_reg          <= state_next;
      count_reg          <= count_next;
      // Edge registers always track their inputs, so an event seen while the
      // other list is granted is consumed rather than deferred.
      served_control_reg <= served_control_i;
      served_bulk_reg    <= served_bulk_i;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;

    if (!nonperiodic_en_i) begin
      // Losing the frame permission overrides everything; count is kept.
      state_next = ST_IDLE;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (control_eligible) begin
            state_next = ST_CONTROL;
            count_next = ratio_i;
          end else if (bulk_eligible) begin
            state_next = ST_BULK;
          end
        end

        ST_CONTROL: begin
          // A served event is handled before any eligibility change.
          if (control_event) begin
            if (count_reg != '0) begin
              count_next = count_reg - RATIO_WIDTH'(1);
            end else if (bulk_eligible) begin
              state_next = ST_BULK;
            end else begin
              // Ratio complete but bulk has nothing to do: start a new round.
              count_next = ratio_i;
            end
          end else if (!control_eligible) begin
            state_next = bulk_eligible ? ST_BULK : ST_IDLE;
          end
        end

        ST_BULK: begin
          if (bulk_event) begin
            if (control_eligible) begin
              state_next = ST_CONTROL;
              count_next = ratio_i;
            end
          end else if (!bulk_eligible) begin
            if (control_eligible) begin
              state_next = ST_CONTROL;
              count_next = ratio_i;
            end else begin
              state_next = ST_IDLE;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign select_control_o = (state_reg == ST_CONTROL);
  assign select_bulk_o    = (state_reg == ST_BULK);
  assign idle_o           = (state_reg == ST_IDLE);
  assign count_o          = count_reg;
  assign last_control_o   = (state_reg == ST_CONTROL) && (count_reg == '0);

endmodule

// File: tb/tb_new_usb_nonperiodic_arbiter.sv
// Scoreboard bench for new_usb_nonperiodic_arbiter (RATIO_WIDTH=4).
// The driver applies one cycle of stimulus per step and queues the output
// vector expected after the next clock edge, tagged with that cycle number.
// The monitor compares on every falling edge (and on demand for async reset).
module tb_new_usb_nonperiodic_arbiter;

  localparam int RW = 4;
  localparam int VW = RW + 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          nonperiodic_en_i = 1'b0;
  logic          control_enable_i = 1'b0;
  logic          bulk_enable_i = 1'b0;
  logic          control_filled_i = 1'b0;
  logic          bulk_filled_i = 1'b0;
  logic [RW-1:0] ratio_i = '0;
  logic          served_control_i = 1'b0;
  logic          served_bulk_i = 1'b0;
  logic          select_control_o;
  logic          select_bulk_o;
  logic          idle_o;
  logic [RW-1:0] count_o;
  logic          last_control_o;

  new_usb_nonperiodic_arbiter #(.RATIO_WIDTH(RW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .nonperiodic_en_i (nonperiodic_en_i),
    .control_enable_i (control_enable_i),
    .bulk_enable_i    (bulk_enable_i),
    .control_filled_i (control_filled_i),
    .bulk_filled_i    (bulk_filled_i),
    .ratio_i          (ratio_i),
    .served_control_i (served_control_i),
    .served_bulk_i    (served_bulk_i),
    .select_control_o (select_control_o),
    .select_bulk_o    (select_bulk_o),
    .idle_o           (idle_o),
    .count_o          (count_o),
    .last_control_o   (last_control_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef enum {E_I, E_C, E_B} exp_st_t;
  typedef struct {
    int           cyc;
    logic [VW-1:0] vec;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   step_no = 0;
  event sample_ev;

  // Expected vector: {select_control, select_bulk, idle, last_control, count}
  function automatic logic [VW-1:0] mk(exp_st_t st, int cnt);
    logic [RW-1:0] c;
    c = RW'(cnt);
    return {st == E_C, st == E_B, st == E_I, (st == E_C) && (cnt == 0), c};
  endfunction

  function automatic void push(int tcyc, exp_st_t st, int cnt, string name);
    exp_t e;
    e.cyc  = tcyc;
    e.vec  = mk(st, cnt);
    e.name = name;
    exp_q.push_back(e);
  endfunction

  // One cycle of stimulus: drive served inputs, expect state/count after the edge.
  task automatic step(input logic sc, input logic sb, input exp_st_t st, input int cnt,
                      input string name);
    served_control_i = sc;
    served_bulk_i    = sb;
    step_no++;
    push(cyc + 1, st, cnt, $sformatf("%s#%0d", name, step_no));
    @(negedge clk_i);
  endtask

  // Monitor
  initial begin
    exp_t          e;
    logic [VW-1:0] act;
    forever begin
      @(negedge clk_i or sample_ev);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e   = exp_q.pop_front();
        act = {select_control_o, select_bulk_o, idle_o, last_control_o, count_o};
        n_checks++;
        if (e.cyc != cyc || act !== e.vec) begin
          n_fail++;
          $display("FAIL %s cyc=%0d: actual {selc,selb,idle,last,cnt}=%b required %b (due cyc %0d)",
                   e.name, cyc, act, e.vec, e.cyc);
        end else begin
          $display("ok   %s cyc=%0d outputs=%b", e.name, cyc, act);
        end
        if (select_control_o && select_bulk_o) begin
          n_checks++;
          n_fail++;
          $display("FAIL onehot cyc=%0d: actual both selects 1 required at most one", cyc);
        end
      end
    end
  end

  initial begin
    int wait_cnt;

    // Reset state
    push(1, E_I, 0, "reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Both lists eligible, ratio 2: C,C,C then B, repeated
    nonperiodic_en_i = 1'b1;
    control_enable_i = 1'b1;
    bulk_enable_i    = 1'b1;
    control_filled_i = 1'b1;
    bulk_filled_i    = 1'b1;
    ratio_i          = 4'd2;
    step(0, 0, E_C, 2, "r2_enter");
    step(1, 0, E_C, 1, "r2_p1");
    step(0, 0, E_C, 1, "r2_p1lo");
    step(1, 0, E_C, 0, "r2_p2");
    step(0, 0, E_C, 0, "r2_p2lo");
    step(1, 0, E_B, 0, "r2_p3_bulk");
    step(0, 0, E_B, 0, "r2_bulk_hold");
    step(1, 0, E_B, 0, "r2_ctrl_ign");
    step(0, 1, E_C, 2, "r2_bulk_srv");
    step(0, 0, E_C, 2, "r2_c2");
    step(1, 0, E_C, 1, "r2_p4");
    step(0, 0, E_C, 1, "r2_p4lo");
    step(1, 0, E_C, 0, "r2_p5");
    step(0, 0, E_C, 0, "r2_p5lo");
    step(1, 0, E_B, 0, "r2_p6_bulk");
    step(0, 0, E_B, 0, "r2_b2");

    // ratio 0, bulk empty: stays in CONTROL, count reloads to 0
    ratio_i       = 4'd0;
    bulk_filled_i = 1'b0;
    step(0, 0, E_C, 0, "r0_enter");
    step(1, 0, E_C, 0, "r0_p1");
    step(0, 0, E_C, 0, "r0_p1lo");
    step(1, 0, E_C, 0, "r0_p2");
    step(0, 0, E_C, 0, "r0_p2lo");

    // Bulk pulse with control unfilled stays in BULK; later pulse -> CONTROL
    bulk_filled_i    = 1'b1;
    control_filled_i = 1'b0;
    ratio_i          = 4'd3;
    step(0, 0, E_B, 0, "bk_enter");
    step(0, 1, E_B, 0, "bk_srv_noctl");
    control_filled_i = 1'b1;
    step(0, 0, E_B, 0, "bk_ctl_filled");
    step(0, 1, E_C, 3, "bk_srv_ctl");
    step(0, 0, E_C, 3, "bk_c3");

    // served_control held high 5 cycles: one decrement only
    for (int i = 0; i < 5; i++) step(1, 0, E_C, 2, "hold_sc");
    step(0, 0, E_C, 2, "hold_release");

    // Enable dropped while a pulse arrives: IDLE, count unchanged
    nonperiodic_en_i = 1'b0;
    step(1, 0, E_I, 2, "en_drop");
    step(0, 0, E_I, 2, "en_low");
    nonperiodic_en_i = 1'b1;
    step(0, 0, E_C, 3, "en_back");

    // Eligibility loss paths
    control_filled_i = 1'b0;
    bulk_filled_i    = 1'b0;
    step(0, 0, E_I, 3, "none_elig");
    bulk_filled_i = 1'b1;
    step(0, 0, E_B, 3, "idle_to_bulk");
    bulk_filled_i = 1'b0;
    step(0, 0, E_I, 3, "bulk_to_idle");
    bulk_filled_i    = 1'b1;
    control_filled_i = 1'b1;

    // ratio 15, seven pulses, then asynchronous reset
    ratio_i = 4'd15;
    step(0, 0, E_C, 15, "r15_enter");
    for (int k = 1; k <= 7; k++) begin
      step(1, 0, E_C, 15 - k, "r15_p");
      step(0, 0, E_C, 15 - k, "r15_plo");
    end
    #2;
    rst_ni = 1'b0;
    #1;
    push(cyc, E_I, 0, "async_reset");
    ->sample_ev;
    push(cyc + 1, E_I, 0, "reset_held");
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(0, 0, E_C, 15, "r15_reenter");
    step(1, 0, E_C, 14, "r15_after");
    step(0, 0, E_C, 14, "r15_afterlo");

    // Drain the scoreboard with a bound
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: actual %0d pending expectations required 0", exp_q.size());
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/new_usb_nonperiodic_arbiter.md
NEW_USB_NONPERIODIC_ARBITER -- requirements
Module: new_usb_nonperiodic_arbiter

Interface
REQ-001 SHALL have parameter RATIO_WIDTH, default 2, meaning the width of the control:bulk service ratio field (legal range 1..8).
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port nonperiodic_en_i, input, 1, nonperiodic list processing allowed this frame.
REQ-005 SHALL have ports control_enable_i and bulk_enable_i, input, 1 each, list enables (CLE/BLE).
REQ-006 SHALL have ports control_filled_i and bulk_filled_i, input, 1 each, list filled flags (CLF/BLF).
REQ-007 SHALL have port ratio_i, input, RATIO_WIDTH, control:bulk ratio; ratio_i+1 control EDs are served per bulk ED.
REQ-008 SHALL have ports served_control_i and served_bulk_i, input, 1 each, level "ED served" indications; only rising edges count.
REQ-009 SHALL have ports select_control_o and select_bulk_o, output, 1 each, the list currently granted (one-hot or both 0).
REQ-010 SHALL have port idle_o, output, 1, no list granted.
REQ-011 SHALL have port count_o, output, RATIO_WIDTH, remaining control EDs before the bulk turn.
REQ-012 SHALL have port last_control_o, output, 1, the next served control ED completes the ratio.

Function
REQ-013 SHALL define control eligible = control_enable_i & control_filled_i, and bulk eligible = bulk_enable_i & bulk_filled_i.
REQ-014 SHALL register served_control_i and served_bulk_i (reset 0); the served event is input high while its registered value is low, one event per rising edge.
REQ-015 SHALL implement the FSM states IDLE, CONTROL and BULK; outputs decode the registered state, so grant changes are visible one cycle after the causing input.
REQ-016 SHALL, from any state, go to IDLE when nonperiodic_en_i=0; this takes priority over all other transitions.
REQ-017 SHALL, in IDLE with enable high, go to CONTROL and load count=ratio_i if control is eligible; otherwise go to BULK if bulk is eligible; otherwise stay in IDLE.
REQ-018 SHALL, in CONTROL on a control served event: decrement count if count≠0; if count=0 go to BULK if bulk is eligible, otherwise reload count=ratio_i and stay in CONTROL.
REQ-019 SHALL, in CONTROL with no served event and control ineligible, go to BULK if bulk is eligible, otherwise go to IDLE.
REQ-020 SHALL, in BULK on a bulk served event, go to CONTROL and load count=ratio_i if control is eligible, otherwise stay in BULK.
REQ-021 SHALL, in BULK with no served event and bulk ineligible, go to CONTROL (loading count=ratio_i) if control is eligible, otherwise go to IDLE.
REQ-022 SHALL act on a served event before eligibility loss in the same cycle; the event of the non-granted list is ignored and consumed (the edge register still updates).
REQ-023 SHALL sample ratio_i only at load/reload; changes while in CONTROL do not affect the running count.
REQ-024 SHALL keep count unsigned, never wrap below 0, and hold it when not in CONTROL.
REQ-025 SHALL assert last_control_o = (state==CONTROL) & (count==0).
REQ-026 SHALL assert idle_o = (state==IDLE); select_control_o and select_bulk_o are never both 1.

Reset
REQ-027 SHALL, while rst_ni=0, force state=IDLE, count=0, edge registers=0, select_control_o=0, select_bulk_o=0, idle_o=1, last_control_o=0 and count_o=0, asynchronously.
REQ-028 SHALL, on reset assertion mid-operation, abandon the grant immediately; after release, arbitration restarts from IDLE with count reloaded on the next CONTROL entry.

Verification
REQ-029 SHALL cover: ratio_i=2, both lists eligible, en=1, six control pulses -> grant sequence C,C,C,B; count_o 2→1→0; last_control_o is high only at count 0; BULK is entered 1 cycle after the third pulse edge.
REQ-030 SHALL cover: ratio_i=0, bulk_filled_i=0 -> stays in CONTROL; count reloads to 0 after every pulse; select_bulk_o is never asserted.
REQ-031 SHALL cover: in BULK, a bulk pulse and control_filled_i=0 in the same cycle -> stays in BULK; with control_filled_i then set, the next bulk pulse -> CONTROL with count_o=ratio_i.
REQ-032 SHALL cover: served_control_i held high for 5 cycles in CONTROL, ratio_i=3 -> count_o decrements once (3→2).
REQ-033 SHALL cover: nonperiodic_en_i dropped during CONTROL while a served pulse arrives -> IDLE next cycle; count_o is unchanged.
REQ-034 SHALL cover: RATIO_WIDTH=4, ratio_i=15, with rst_ni asserted after 7 pulses -> all outputs at reset values immediately; after release, count_o=15 on re-entering CONTROL.
